token_rate_scheduler: RTL

- Serial token controller. It decimates several 1-bit token streams at a per-channel ratio and merges the results onto one shared serial token output.
- Each channel keeps a credit count of decimated tokens not yet sent. A round-robin scheduler drains one credit per cycle onto `b`, tagged with the channel id.
- It sits upstream of any single-token-per-cycle consumer and generalises the fixed 2:1 halving stage to N channels with configurable ratios.

---
 rtl/token_rate_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/token_rate_scheduler.sv
// Decimates N_CH 1-bit token streams at per-channel ratios and merges the
// resulting credits onto one registered serial output via a round-robin arbiter.
module token_rate_scheduler #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 4,
  parameter int DIV_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         a,
  input  logic                    en,
  input  logic                    cfg_vld,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]        cfg_div,
  output logic                    b,
  output logic [$clog2(N_CH)-1:0] b_ch,
  output logic [N_CH-1:0]         ovf,
  output logic                    busy
);

  localparam int CH_W = $clog2(N_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(2);

  // cfg_vld is a one-cycle write strobe with no ready: every in-range write is
  // accepted at the edge it is sampled on; out-of-range channels are dropped.

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              b_q, b_d;
  logic [CH_W-1:0]   b_ch_q, b_ch_d;
  logic              busy_q, busy_d;
  logic [N_CH-1:0]   ovf_q, ovf_d;
  logic [DIV_W-1:0]  div_q [N_CH];
  logic [DIV_W-1:0]  div_d [N_CH];
  logic [DIV_W-1:0]  phase_q [N_CH];
  logic [DIV_W-1:0]  phase_d [N_CH];
  logic [CNT_W-1:0]  pend_q [N_CH];
  logic [CNT_W-1:0]  pend_d [N_CH];

  logic [N_CH-1:0]   credit;
  logic [N_CH-1:0]   gnt;
  logic              cfg_hit;
  logic              win_vld;
  logic [CH_W-1:0]   win;
  int                idx;

  assign cfg_hit = cfg_vld && (int'(cfg_ch) < N_CH);

  // Decimation: a token is evaluated against the current div/phase, then a
  // config write to the same channel overrides the phase result.
  always_comb begin
    credit = '0;
    for (int i = 0; i < N_CH; i++) begin
      div_d[i]   = div_q[i];
      phase_d[i] = phase_q[i];
      if (a[i] && (div_q[i] != '0)) begin
        if (phase_q[i] == div_q[i] - DIV_W'(1)) begin
          credit[i]  = 1'b1;
          phase_d[i] = '0;
        end else begin
          phase_d[i] = phase_q[i] + DIV_W'(1);
        end
      end
    end
    if (cfg_hit) begin
      div_d[cfg_ch]   = cfg_div;
      phase_d[cfg_ch] = '0;
    end
  end

  // Round-robin search starting strictly after the last granted channel.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    idx     = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(ptr_q) + k) % N_CH;
      if (!win_vld && (pend_q[idx] != '0)) begin
        win_vld = 1'b1;
        win     = CH_W'(idx);
      end
    end
  end

  // Scheduler: en low freezes state and pointer and suppresses any grant.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    b_d     = 1'b0;
    b_ch_d  = '0;
    gnt     = '0;
    if (en) begin
      if (win_vld) begin
        state_d  = S_GRANT;
        gnt[win] = 1'b1;
        b_d      = 1'b1;
        b_ch_d   = win;
        ptr_d    = win;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_comb begin
    ovf_d  = ovf_q;
    busy_d = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      pend_d[i] = pend_q[i];
      if (credit[i] && !gnt[i]) begin
        if (pend_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          pend_d[i] = pend_q[i] + CNT_W'(1);
        end
      end else if (!credit[i] && gnt[i]) begin
        pend_d[i] = pend_q[i] - CNT_W'(1);
      end
      if (pend_d[i] != '0) begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= CH_W'(N_CH - 1);
      b_q     <= 1'b0;
      b_ch_q  <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        div_q[i]   <= DIV_RST;
        phase_q[i] <= '0;
        pend_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      b_q     <= b_d;
      b_ch_q  <= b_ch_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < N_CH; i++) begin
        div_q[i]   <= div_d[i];
        phase_q[i] <= phase_d[i];
        pend_q[i]  <= pend_d[i];
      end
    end
  end

  assign b    = b_q;
  assign b_ch = b_ch_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;

endmodule
